// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction kinds and field widths
// used by both the program writer and the core's control_unit decode.
package mips_pkg;

  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int INSTR_W  = 32;
  localparam int KIND_W   = 3;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_HLT   = 6'b111111;

  typedef enum logic [KIND_W-1:0] {
    KIND_R       = 3'd0,
    KIND_LW      = 3'd1,
    KIND_SW      = 3'd2,
    KIND_BEQ     = 3'd3,
    KIND_ADDI    = 3'd4,
    KIND_J       = 3'd5,
    KIND_HLT     = 3'd6,
    KIND_ILLEGAL = 3'd7
  } instr_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/imem_program_writer_if.sv
// Descriptor handshake between a program source and the instruction-memory writer.
interface imem_program_writer_if;
  import mips_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [KIND_W-1:0]   in_kind;
  logic [REG_W-1:0]    in_rs;
  logic [REG_W-1:0]    in_rt;
  logic [REG_W-1:0]    in_rd;
  logic [SHAMT_W-1:0]  in_shamt;
  logic [FUNCT_W-1:0]  in_funct;
  logic [IMM_W-1:0]    in_imm;
  logic [TARGET_W-1:0] in_target;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    output in_ready
  );

endinterface

// File: rtl/instr_encoder.sv
// Combinational encoder: symbolic descriptor to 32-bit MIPS word, flags kind 7.
module instr_encoder
  import mips_pkg::*;
(
  input  logic [KIND_W-1:0]   kind,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TARGET_W-1:0] target,
  output logic [INSTR_W-1:0]  word,
  output logic                illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (instr_kind_e'(kind))
      KIND_R:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:   word = {OP_LW, rs, rt, imm};
      KIND_SW:   word = {OP_SW, rs, rt, imm};
      KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
      KIND_J:    word = {OP_J, target};
      KIND_HLT:  word = {OP_HLT, {TARGET_W{1'b0}}};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_writer.sv
// Loads encoded instructions into instruction memory from address 0, one word
// per two cycles, stopping on HLT or when DEPTH words have been written.
module imem_program_writer
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  imem_program_writer_if.slave bus,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0]   imem_wdata,
  output logic [ADDR_W:0]      count,
  output logic                 done,
  output logic                 error
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  wr_state_e            state_q, state_d;
  logic [INSTR_W-1:0]   enc_word;
  logic                 enc_illegal;
  logic                 accept;
  logic                 last_is_hlt;
  logic [ADDR_W:0]      count_inc;

  instr_encoder u_enc (
    .kind    (bus.in_kind),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .shamt   (bus.in_shamt),
    .funct   (bus.in_funct),
    .imm     (bus.in_imm),
    .target  (bus.in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign bus.in_ready = (state_q == ST_IDLE);
  assign imem_we      = (state_q == ST_WRITE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_is_hlt  = (imem_wdata[INSTR_W-1 -: OPCODE_W] == OP_HLT);
  assign count_inc    = count + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !enc_illegal) state_d = ST_WRITE;
      ST_WRITE: state_d = (last_is_hlt || count_inc == DEPTH_CNT) ? ST_DONE : ST_IDLE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // Address, count and status; clear restarts the load but keeps the last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (clear) begin
      imem_addr  <= '0;
      count      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (enc_illegal) error      <= 1'b1;
            else             imem_wdata <= enc_word;
          end
        end
        ST_WRITE: begin
          count <= count_inc;
          if (last_is_hlt) begin
            done <= 1'b1;
          end else if (count_inc == DEPTH_CNT) begin
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            imem_addr <= imem_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_writer.sv
// Bench for imem_program_writer: directed and randomized descriptors against a
// field-arithmetic encoding model and an address/count model.
module tb_imem_program_writer;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear0, clear1;
  logic        imem_we0, done0, error0;
  logic [5:0]  addr0;
  logic [31:0] wdata0;
  logic [6:0]  count0;
  logic        imem_we1, done1, error1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;
  logic [2:0]  count1;

  imem_program_writer_if if0 ();
  imem_program_writer_if if1 ();

  imem_program_writer #(.ADDR_W(6), .DEPTH(64)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .bus(if0.slave),
    .imem_we(imem_we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .count(count0), .done(done0), .error(error0)
  );

  imem_program_writer #(.ADDR_W(2), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(if1.slave),
    .imem_we(imem_we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .count(count1), .done(done1), .error(error1)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  int          exp_addr, exp_count;
  bit          exp_done, exp_err;
  logic [31:0] last_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int kind, input int rs, input int rt,
      input int rd, input int sh, input int fn, input int imm, input int tgt);
    logic [31:0] regs;
    regs = 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536;
    case (kind)
      0: return regs + 32'(rd) * 32'd2048 + 32'(sh) * 32'd64 + 32'(fn);
      1: return 32'd35 * 32'd67108864 + regs + 32'(imm);
      2: return 32'd43 * 32'd67108864 + regs + 32'(imm);
      3: return 32'd4  * 32'd67108864 + regs + 32'(imm);
      4: return 32'd8  * 32'd67108864 + regs + 32'(imm);
      5: return 32'd2  * 32'd67108864 + 32'(tgt);
      6: return 32'd63 * 32'd67108864;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_restart();
    exp_addr = 0; exp_count = 0; exp_done = 0; exp_err = 0;
  endtask

  task automatic pulse_clear0();
    clear0 = 1'b1;
    @(posedge clk); #1;
    clear0 = 1'b0;
    model_restart();
  endtask

  task automatic apply0(input int k, input int rs, input int rt, input int rd,
      input int sh, input int fn, input int imm, input int tgt);
    int waitc = 0;
    logic [31:0] ew;
    while (!if0.in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!if0.in_ready) begin
      chk("ready_timeout", 1'b0, 1'b1);
      return;
    end
    if0.in_kind = 3'(k);    if0.in_rs = 5'(rs);     if0.in_rt = 5'(rt);
    if0.in_rd = 5'(rd);     if0.in_shamt = 5'(sh);  if0.in_funct = 6'(fn);
    if0.in_imm = 16'(imm);  if0.in_target = 26'(tgt);
    if0.in_valid = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    if (k == 7) begin
      exp_err = 1;
      chk("ill_no_we", imem_we0, 1'b0);
      chk("ill_error", error0, 1'b1);
      chk("ill_ready", if0.in_ready, 1'b1);
      chk("ill_count", count0, exp_count);
      chk("ill_addr", addr0, exp_addr);
    end else begin
      ew = model_word(k, rs, rt, rd, sh, fn, imm, tgt);
      chk("we", imem_we0, 1'b1);
      chk("addr", addr0, exp_addr);
      chk("wdata", wdata0, ew);
      chk("busy", if0.in_ready, 1'b0);
      last_wdata = wdata0;
      @(posedge clk); #1;
      exp_count++;
      if (k == 6) exp_done = 1;
      else if (exp_count == 64) begin exp_done = 1; exp_err = 1; end
      else exp_addr++;
      chk("count", count0, exp_count);
      chk("done", done0, exp_done);
      chk("error", error0, exp_err);
      chk("addr_next", addr0, exp_addr);
      chk("we_drop", imem_we0, 1'b0);
      chk("ready_back", if0.in_ready, !exp_done);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not reach summary");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear0 = 1'b0; clear1 = 1'b0;
    if0.in_valid = 0; if0.in_kind = 0; if0.in_rs = 0; if0.in_rt = 0; if0.in_rd = 0;
    if0.in_shamt = 0; if0.in_funct = 0; if0.in_imm = 0; if0.in_target = 0;
    if1.in_valid = 0; if1.in_kind = 0; if1.in_rs = 0; if1.in_rt = 0; if1.in_rd = 0;
    if1.in_shamt = 0; if1.in_funct = 0; if1.in_imm = 0; if1.in_target = 0;
    model_restart();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", if0.in_ready, 1'b1);
    chk("rst_we", imem_we0, 1'b0);
    chk("rst_addr", addr0, 0);
    chk("rst_wdata", wdata0, 0);
    chk("rst_count", count0, 0);
    chk("rst_done", done0, 1'b0);
    chk("rst_error", error0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    apply0(0, 1, 2, 3, 0, 32, 0, 0);
    chk("r_add_word", last_wdata, 32'h00221820);

    pulse_clear0();
    apply0(1, 0, 8, 0, 0, 0, 10, 0);
    chk("lw_word", last_wdata, 32'h8C08000A);
    apply0(2, 0, 8, 0, 0, 0, 12, 0);
    chk("sw_word", last_wdata, 32'hAC08000C);
    chk("sw_addr", addr0, 2);

    pulse_clear0();
    apply0(5, 0, 0, 0, 0, 0, 0, 4);
    chk("j_word", last_wdata, 32'h08000004);
    apply0(6, 0, 0, 0, 0, 0, 0, 0);
    chk("hlt_word", last_wdata, 32'hFC000000);
    chk("hlt_count", count0, 2);
    chk("hlt_done", done0, 1'b1);
    chk("hlt_error", error0, 1'b0);
    if0.in_kind = 3'd0; if0.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("done_no_we", imem_we0, 1'b0);
      chk("done_no_ready", if0.in_ready, 1'b0);
      chk("done_count", count0, 2);
    end
    if0.in_valid = 1'b0;

    pulse_clear0();
    apply0(4, 1, 1, 0, 0, 0, 16'hFFFF, 0);
    chk("addi0_word", last_wdata, 32'h2021FFFF);
    apply0(7, 0, 0, 0, 0, 0, 0, 0);
    apply0(4, 2, 3, 0, 0, 0, 5, 0);
    chk("addi1_word", last_wdata, 32'h20430005);
    chk("addi1_error", error0, 1'b1);
    chk("addi1_count", count0, 2);

    pulse_clear0();
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 6));
      if (k == 6) k = 7;
      apply0(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 32'h3FFFFFF)));
    end
    apply0(6, 0, 0, 0, 0, 0, 0, 0);
    chk("rand_done", done0, 1'b1);

    // reset landing on the write cycle drops the pending write
    pulse_clear0();
    if0.in_kind = 3'd0; if0.in_rs = 5'd4; if0.in_valid = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    chk("mid_we", imem_we0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_count", count0, 0);
    chk("mid_addr", addr0, 0);
    chk("mid_we_off", imem_we0, 1'b0);
    chk("mid_ready", if0.in_ready, 1'b1);
    model_restart();

    apply0(6, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_clr_done", done0, 1'b1);
    if0.in_kind = 3'd0; if0.in_rs = 5'd9; if0.in_valid = 1'b1; clear0 = 1'b1;
    @(posedge clk); #1;
    clear0 = 1'b0; if0.in_valid = 1'b0;
    chk("clr_ready", if0.in_ready, 1'b1);
    chk("clr_we", imem_we0, 1'b0);
    chk("clr_count", count0, 0);
    chk("clr_done", done0, 1'b0);
    chk("clr_error", error0, 1'b0);
    chk("clr_wdata_kept", wdata0, 32'hFC000000);
    @(posedge clk); #1;
    chk("clr_no_write", imem_we0, 1'b0);

    // small memory: fills after four words without HLT
    for (int i = 0; i < 4; i++) begin
      if1.in_kind = 3'd4; if1.in_rs = 5'(i); if1.in_rt = 5'd1;
      if1.in_imm = 16'($urandom_range(0, 65535)); if1.in_valid = 1'b1;
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      chk("full_we", imem_we1, 1'b1);
      chk("full_addr", addr1, i);
      chk("full_wdata", wdata1, model_word(4, i, 1, 0, 0, 0, int'(if1.in_imm), 0));
      @(posedge clk); #1;
      chk("full_count", count1, i + 1);
      chk("full_done", done1, i == 3);
      chk("full_error", error1, i == 3);
    end
    chk("full_addr_hold", addr1, 3);
    if1.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("fifth_no_we", imem_we1, 1'b0);
      chk("fifth_no_ready", if1.in_ready, 1'b0);
      chk("fifth_count", count1, 4);
    end
    if1.in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_program_writer.md
Name: imem_program_writer

Overview:
- Encoder and writer counterpart to the opcode decoder in the single-cycle MIPS core.
- Accepts symbolic instruction descriptors over a valid/ready handshake and encodes each one into a 32-bit MIPS word.
- Writes the words sequentially into instruction memory, starting at word address 0.
- Stops when HLT is written or memory is full. Used by the bench and boot path to load programs before the core runs.

Parameters:
- ADDR_W, 6, instruction-memory word-address width.
- DEPTH, 64, number of writable words (must be ≤ 2**ADDR_W).

Ports:
- clk  in  1  single clock, all logic on the rising edge
- rst_n  in  1  synchronous reset, active-low
- clear  in  1  synchronous restart: return to IDLE, clear address/count/error
- in_valid  in  1  descriptor valid
- in_ready  out  1  writer can accept a descriptor
- in_kind  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6=HLT, 7=illegal
- in_rs  in  5  source register
- in_rt  in  5  target register
- in_rd  in  5  destination register (R only)
- in_shamt  in  5  shift amount (R only)
- in_funct  in  6  function field (R only)
- in_imm  in  16  immediate/offset (LW, SW, BEQ, ADDI)
- in_target  in  26  jump target (J only)
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written so far
- done  out  1  load finished (HLT written or full)
- error  out  1  sticky: illegal kind seen, or memory full without HLT

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE
  - in_ready=1
  - imem_we=0, imem_addr=0, imem_wdata=0
  - count=0, done=0, error=0
- Reset is honoured in any state, including mid-write; a pending write is dropped.
- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready.
  - Legal kind: register the encoded word into imem_wdata; go to WRITE.
  - Kind 7: set error and stay in IDLE; nothing is written and the address does not advance.
- WRITE:
  - in_ready=0; imem_we=1 for exactly one cycle at the current imem_addr.
  - Next edge: count+=1.
  - If the word was HLT: done=1, go to DONE, address holds.
  - Else if count+1 == DEPTH: error=1, done=1, go to DONE.
  - Else: imem_addr+=1, return to IDLE.
- Latency and throughput:
  - Descriptor accepted at edge N → imem_we high during cycle N+1.
  - in_ready high again in cycle N+2, giving one instruction per 2 cycles.
- DONE:
  - in_ready=0, imem_we=0; outputs hold.
  - Only clear or rst_n leaves DONE.
- clear:
  - Same effect as reset, but does not alter imem_wdata.
  - If clear and in_valid occur together, clear has priority and the descriptor is not accepted.
- Encoding (fields MSB→LSB):
  - R: {000000, rs, rt, rd, shamt, funct}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - ADDI: {001000, rs, rt, imm}
  - J: {000010, target}
  - HLT: {111111, 26'b0}
- Fields that a kind does not use are ignored.
- imem_addr never wraps. Addresses ≥ DEPTH are never written.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HLT
  - instruction-kind enum
  - field-width constants
- The control_unit decode must use the same opcode constants.
- One natural sub-module: instr_encoder, purely combinational (kind + fields → 32-bit word, plus an illegal flag). The FSM, address and count logic stay in the top block.

Test Plan:
- Reset then R add: kind=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20 → imem_we in cycle N+1, addr=0, wdata=0x00221820, count=1.
- LW then SW: LW rs=0, rt=8, imm=10 → addr 0, wdata=0x8C08000A; SW rs=0, rt=8, imm=12 → addr 1, wdata=0xAC08000C; in_ready low exactly one cycle per write.
- J target=0x0000004 then HLT → wdata 0x08000004 at addr 0, then 0xFC000000 at addr 1; done=1, count=2, error=0; further in_valid ignored.
- Illegal kind=7 between two ADDIs → error=1, no write for it. ADDI words land at addr 0 and 1: ADDI rs=1, rt=1, imm=0xFFFF → 0x2021FFFF.
- DEPTH=4, five non-HLT descriptors → four writes at addr 0..3; done=1, error=1 after the fourth; fifth never accepted.
- Mid-stream reset: rst_n=0 in the WRITE cycle → no increment, addr=0, count=0. Then clear asserted in DONE together with in_valid → IDLE, descriptor not accepted.
